// File: rtl/data_sram_1r1w_if.sv
// Request/response bundle for the 1R1W data SRAM: read port R0, write port W0, init status.
interface data_sram_1r1w_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned NLANES = 1
);
  logic [ADDR_W-1:0] R0_addr;
  logic              R0_en;
  logic [WIDTH-1:0]  R0_data;
  logic              R0_valid;
  logic [ADDR_W-1:0] W0_addr;
  logic              W0_en;
  logic [WIDTH-1:0]  W0_data;
  logic [NLANES-1:0] W0_mask;
  logic              init_busy;

  modport master (
    output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    input  R0_data, R0_valid, init_busy
  );

  modport slave (
    input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    output R0_data, R0_valid, init_busy
  );
endinterface

// File: rtl/data_sram_1r1w.sv
// 1R1W data SRAM with lane write mask, self-clearing after reset, registered read port.
// Optional macro DATA_SRAM_RDW_BYPASS_EN: same-address read/write returns newly written lanes.
module data_sram_1r1w #(
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned MASK_GRAN = WIDTH
) (
  input logic              clock,
  input logic              reset_n,
  data_sram_1r1w_if.slave  bus
);
  localparam int unsigned ADDR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NLANES = WIDTH / MASK_GRAN;
  localparam int unsigned CMP_W  = ADDR_W + 1;
  localparam logic [CMP_W-1:0]  LIMIT = CMP_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               r_valid_q;
  logic [WIDTH-1:0]   r_data_q;

  logic [WIDTH-1:0]   mem [DEPTH];

  logic               w_in_range_c, r_in_range_c;
  logic               mem_we_c, rd_en_c;
  logic [ADDR_W-1:0]  mem_wa_c;
  logic [WIDTH-1:0]   mem_wd_c, rd_word_c;
  logic [NLANES-1:0]  mem_wm_c;

  assign w_in_range_c = {1'b0, bus.W0_addr} < LIMIT;
  assign r_in_range_c = {1'b0, bus.R0_addr} < LIMIT;

  // Next state, clear sequencing and array write-port steering
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b1;
    mem_we_c = 1'b0;
    mem_wa_c = bus.W0_addr;
    mem_wd_c = bus.W0_data;
    mem_wm_c = bus.W0_mask;
    rd_en_c  = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        mem_we_c = 1'b1;
        mem_wa_c = cnt_q;
        mem_wd_c = '0;
        mem_wm_c = '1;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        busy_d   = 1'b0;
        mem_we_c = bus.W0_en && w_in_range_c;
        rd_en_c  = bus.R0_en;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Read word; out-of-range addresses read as zero
  always_comb begin
    rd_word_c = r_in_range_c ? mem[bus.R0_addr] : '0;
`ifdef DATA_SRAM_RDW_BYPASS_EN
    if (bus.W0_en && w_in_range_c && (bus.W0_addr == bus.R0_addr)) begin
      for (int unsigned i = 0; i < NLANES; i++) begin
        if (bus.W0_mask[i]) rd_word_c[i*MASK_GRAN +: MASK_GRAN] = bus.W0_data[i*MASK_GRAN +: MASK_GRAN];
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      r_valid_q <= rd_en_c;
      if (rd_en_c) r_data_q <= rd_word_c;
    end
  end

  // Array is never reset; the INIT sweep clears it
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      for (int unsigned i = 0; i < NLANES; i++) begin
        if (mem_wm_c[i]) mem[mem_wa_c][i*MASK_GRAN +: MASK_GRAN] <= mem_wd_c[i*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  assign bus.R0_data   = r_data_q;
  assign bus.R0_valid  = r_valid_q;
  assign bus.init_busy = busy_q;
endmodule

// File: tb/tb_data_sram_1r1w.sv
// Randomized bench for data_sram_1r1w (DEPTH=100, 32-bit words, byte lanes) against a behavioural model.
module tb_data_sram_1r1w;
  localparam int unsigned DEPTH  = 100;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned GRAN   = 8;
  localparam int unsigned NLANES = WIDTH / GRAN;
  localparam int unsigned AW     = 7;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  data_sram_1r1w_if #(.ADDR_W(AW), .WIDTH(WIDTH), .NLANES(NLANES)) bus ();

  data_sram_1r1w #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(GRAN)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: memory reads as zero once DEPTH clear cycles have elapsed
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               init_left = DEPTH;
  logic             exp_busy  = 1'b1;
  logic             exp_valid = 1'b0;
  logic [WIDTH-1:0] exp_data  = '0;
  logic [WIDTH-1:0] m_rd;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_left = DEPTH;
      exp_busy  = 1'b1;
      exp_valid = 1'b0;
      exp_data  = '0;
    end else if (init_left > 0) begin
      init_left = init_left - 1;
      exp_valid = 1'b0;
      if (init_left == 0) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        exp_busy = 1'b0;
      end
    end else begin
      exp_valid = bus.R0_en;
      if (bus.R0_en) begin
        m_rd = '0;
        if (int'(bus.R0_addr) < DEPTH) begin
          m_rd = m_mem[bus.R0_addr];
`ifdef DATA_SRAM_RDW_BYPASS_EN
          if (bus.W0_en && bus.W0_addr == bus.R0_addr)
            for (int l = 0; l < NLANES; l++)
              if (bus.W0_mask[l]) m_rd[l*GRAN +: GRAN] = bus.W0_data[l*GRAN +: GRAN];
`endif
        end
        exp_data = m_rd;
      end
      if (bus.W0_en && int'(bus.W0_addr) < DEPTH)
        for (int l = 0; l < NLANES; l++)
          if (bus.W0_mask[l]) m_mem[bus.W0_addr][l*GRAN +: GRAN] = bus.W0_data[l*GRAN +: GRAN];
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    check("cmp_busy",  32'(bus.init_busy), 32'(exp_busy));
    check("cmp_valid", 32'(bus.R0_valid),  32'(exp_valid));
    check("cmp_data",  bus.R0_data,        exp_data);
  end

  task automatic drive(input logic ren, input logic [AW-1:0] ra, input logic wen,
                       input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd, input logic [NLANES-1:0] wm);
    bus.R0_en = ren; bus.R0_addr = ra;
    bus.W0_en = wen; bus.W0_addr = wa; bus.W0_data = wd; bus.W0_mask = wm;
  endtask

  task automatic cyc(input logic ren, input logic [AW-1:0] ra, input logic wen,
                     input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd, input logic [NLANES-1:0] wm);
    drive(ren, ra, wen, wa, wd, wm);
    @(negedge clock);
    drive(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 15));
    return AW'($urandom_range(0, 127));
  endfunction

  task automatic drive_noise();
    drive(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), rand_addr(),
          WIDTH'($urandom), NLANES'($urandom));
  endtask

  // Called at a negedge just after reset release; counts busy cycles while injecting requests
  task automatic wait_init(input string name);
    int n = 0;
    for (int k = 0; k < DEPTH + 20; k++) begin
      if (!bus.init_busy) break;
      n++;
      drive_noise();
      @(negedge clock);
    end
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    check(name, 32'(n), 32'(DEPTH));
  endtask

  task automatic rand_phase(input int n);
    for (int k = 0; k < n; k++) begin
      drive_noise();
      if ($urandom_range(0, 3) == 0) bus.W0_addr = bus.R0_addr;
      @(negedge clock);
    end
    drive(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"},  32'(bus.init_busy), 32'd1);
    check({tag, "_valid"}, 32'(bus.R0_valid),  32'd0);
    check({tag, "_data"},  bus.R0_data,        32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] rdw_exp;
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    #1 reset_n = 1'b0;
    #1 reset_checks("por");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    wait_init("init_len");

    // Lane-masked merge
    cyc(1'b0, '0, 1'b1, 7'd5, 32'hAABBCCDD, 4'b1111);
    cyc(1'b0, '0, 1'b1, 7'd5, 32'h11223344, 4'b0101);
    cyc(1'b1, 7'd5, 1'b0, '0, '0, '0);
    check("mask_merge", bus.R0_data, 32'hAA22CC44);
    check("mask_valid", 32'(bus.R0_valid), 32'd1);

    // Same-address read during write
`ifdef DATA_SRAM_RDW_BYPASS_EN
    rdw_exp = 32'h0000FFFF;
`else
    rdw_exp = 32'h00000000;
`endif
    cyc(1'b1, 7'd7, 1'b1, 7'd7, 32'hFFFFFFFF, 4'b0011);
    check("rdw_same_cycle", bus.R0_data, rdw_exp);
    cyc(1'b1, 7'd7, 1'b0, '0, '0, '0);
    check("rdw_later", bus.R0_data, 32'h0000FFFF);

    // Out-of-range address
    cyc(1'b0, '0, 1'b1, 7'd120, 32'h3, 4'b1111);
    cyc(1'b1, 7'd120, 1'b0, '0, '0, '0);
    check("oor_data", bus.R0_data, 32'h0);
    check("oor_valid", 32'(bus.R0_valid), 32'd1);
    cyc(1'b1, 7'd99, 1'b0, '0, '0, '0);
    check("addr99_data", bus.R0_data, 32'h0);

    // Back-to-back reads then hold
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, AW'(i), 32'h100 + 32'(i), 4'b1111);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, AW'(i), 1'b0, '0, '0, '0);
      check("b2b_valid", 32'(bus.R0_valid), 32'd1);
      check("b2b_data", bus.R0_data, 32'h100 + 32'(i));
    end
    cyc(1'b0, '0, 1'b0, '0, '0, '0);
    check("hold_valid", 32'(bus.R0_valid), 32'd0);
    check("hold_data", bus.R0_data, 32'h103);
    cyc(1'b0, '0, 1'b0, '0, '0, '0);
    check("hold_data2", bus.R0_data, 32'h103);

    rand_phase(1500);

    // Reset with a read in flight
    drive(1'b1, 7'd5, 1'b0, '0, '0, '0);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 reset_checks("midop");
    @(negedge clock);
    reset_n = 1'b1;
    wait_init("init_len_midop");
    cyc(1'b1, 7'd5, 1'b0, '0, '0, '0);
    check("cleared_addr5", bus.R0_data, 32'h0);

    // Reset when the clear counter has reached 40
    @(negedge clock);
    #2 reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      drive_noise();
      @(negedge clock);
    end
    #2 reset_n = 1'b0;
    #1 reset_checks("midinit");
    @(negedge clock);
    reset_n = 1'b1;
    wait_init("init_len_restart");

    rand_phase(500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end
endmodule
